// File: rtl/router_fifo_if.sv
// Handshake/data bundle between the router output buffer and its neighbours.
// The master side issues writes and reads; the slave side is the FIFO itself.
interface router_fifo_if #(
  parameter int WIDTH = 8
);
  logic             write_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic             read_enb;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             pkt_active;

  modport master (
    output write_enb, lfd_state, data_in, read_enb,
    input  data_out, full, empty, pkt_active
  );

  modport slave (
    input  write_enb, lfd_state, data_in, read_enb,
    output data_out, full, empty, pkt_active
  );
endinterface

// File: rtl/router_fifo.sv
// Per-destination output buffer of the router: stores header-tagged bytes and
// tracks how many bytes of the packet being drained are still outstanding.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           soft_reset,
  router_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [6:0]       count;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH:0]   rd_word;
  logic [6:0]       hdr_count;
  logic             full_int;
  logic             empty_int;
  logic             do_write;
  logic             do_read;

  assign empty_int = (wr_ptr == rd_ptr);
  assign full_int  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_write  = bus.write_enb && !full_int;
  assign do_read   = bus.read_enb && !empty_int;
  assign rd_word   = mem[rd_ptr[AW-1:0]];

  // Header length field counts payload bytes; one more covers the parity byte.
  assign hdr_count = 7'(rd_word[WIDTH-1:2]) + 7'd1;

  always_ff @(posedge clock) begin
    if (!reset && !soft_reset && do_write) begin
      mem[wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data_q <= '0;
    end else if (soft_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      data_q <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        data_q <= rd_word[WIDTH-1:0];
        // Orphan bytes read with no packet open leave the count parked at zero.
        if (rd_word[WIDTH]) begin
          count <= hdr_count;
        end else if (count != 7'd0) begin
          count <= count - 7'd1;
        end
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.full       = full_int;
  assign bus.empty      = empty_int;
  assign bus.pkt_active = (count != 7'd0);
endmodule
